fifo_to_sram_writer: RTL and testbench

Consumes packed 202-bit entries from the output-queue input FIFO (memory-clock side of the async FIFO) and writes them into per-queue circular regions of the shared SRAM. Selects the destination queue from the header entry, checks the free space in that queue's region, drops the packet if the space is insufficient, and commits the packet to the queue only when its last entry has been written. Sits between the AXI-to-FIFO packer's async FIFO and the SRAM controller's write port.

---
 rtl/fifo_to_sram_writer_if.sv | 26 ++
 rtl/fifo_to_sram_writer.sv | 181 ++++++++++++++++++
 tb/tb_fifo_to_sram_writer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_to_sram_writer_if.sv
// FIFO-read and SRAM-write bus between the output-queue FIFO, the writer and the SRAM controller.
// The master side is the writer: it pops the FIFO and issues SRAM write requests.
interface fifo_to_sram_writer_if #(
  parameter int MEM_ADDR_WIDTH = 19,
  parameter int DATA_WIDTH     = 192,
  parameter int NUM_QUEUES     = 5
);
  logic [DATA_WIDTH+9:0]     din;
  logic                      din_valid;
  logic                      rd_en;
  logic [NUM_QUEUES-1:0]     oq;
  logic                      sram_wr_en;
  logic [MEM_ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0]     sram_wr_data;
  logic                      sram_ready;

  modport master (
    input  din, din_valid, oq, sram_ready,
    output rd_en, sram_wr_en, sram_addr, sram_wr_data
  );

  modport slave (
    output din, din_valid, oq, sram_ready,
    input  rd_en, sram_wr_en, sram_addr, sram_wr_data
  );
endinterface

// File: rtl/fifo_to_sram_writer.sv
// Writes packets popped from the output-queue FIFO into per-queue circular SRAM regions,
// admitting a packet only if its queue has room and committing it on its last entry.
module fifo_to_sram_writer #(
  parameter int NUM_QUEUES     = 5,
  parameter int MEM_ADDR_WIDTH = 19,
  parameter int QUEUE_SIZE     = 104857,
  parameter int MAX_PKT_WORDS  = 66,
  parameter int DATA_WIDTH     = 192
) (
  input  logic                               memclk,
  input  logic                               memreset,
  fifo_to_sram_writer_if.master              bus,
  input  logic                               free_valid,
  input  logic [2:0]                         free_qid,
  input  logic [MEM_ADDR_WIDTH-1:0]          free_words,
  output logic                               pkt_done,
  output logic [2:0]                         pkt_qid,
  output logic [MEM_ADDR_WIDTH-1:0]          pkt_words,
  output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_occupancy
);
  localparam int AW = MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t state, next_state;

  logic [AW-1:0] wptr [NUM_QUEUES];
  logic [AW-1:0] cptr [NUM_QUEUES];
  logic [AW-1:0] occ  [NUM_QUEUES];
  logic [2:0]    cur_q;
  logic [AW-1:0] cur_len;

  logic                  wr_en_r;
  logic [AW-1:0]         wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;

  logic          rd_en, take, is_tlast, is_header;
  logic [2:0]    hdr_q;
  logic          hdr_hit, admit;
  logic [AW-1:0] hdr_wptr, hdr_occ, cur_wptr, inflight, wr_addr, len_next;
  logic [AW+1:0] need;
  logic [2:0]    wr_q;
  logic          write_now, commit, rollback;
  logic          unused_strobe;

  function automatic logic [AW-1:0] region_base(input int q);
    return AW'(q * QUEUE_SIZE);
  endfunction

  function automatic logic [AW-1:0] advance(input int q, input logic [AW-1:0] p);
    if (p == region_base(q) + AW'(QUEUE_SIZE - 1)) return region_base(q);
    return p + AW'(1);
  endfunction

  assign unused_strobe = ^bus.din[9:5];

  assign rd_en            = bus.din_valid && ((state == DROP) || !wr_en_r || bus.sram_ready);
  assign bus.rd_en        = rd_en;
  assign bus.sram_wr_en   = wr_en_r;
  assign bus.sram_addr    = wr_addr_r;
  assign bus.sram_wr_data = wr_data_r;

  genvar gq;
  for (gq = 0; gq < NUM_QUEUES; gq++) begin : g_occ
    assign q_occupancy[gq*AW +: AW] = occ[gq];
  end

  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) state <= IDLE;
    else          state <= next_state;
  end

  // A header that also carries tlast is a complete one-word packet, so it never opens
  // a WRITE or DROP phase that would wait for a second tlast.
  always_comb begin
    next_state = state;
    take       = bus.din_valid && rd_en && bus.din[0];
    is_tlast   = bus.din[1];
    is_header  = (bus.din[4:2] == 3'd0);
    hdr_q      = 3'd0;
    hdr_wptr   = '0;
    hdr_occ    = '0;
    cur_wptr   = '0;
    for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
      if (bus.oq[q]) begin
        hdr_q    = 3'(q);
        hdr_wptr = wptr[q];
        hdr_occ  = occ[q];
      end
    end
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (cur_q == 3'(q)) cur_wptr = wptr[q];
    end
    hdr_hit   = |bus.oq;
    inflight  = (state == WRITE) ? cur_len : '0;
    need      = {2'b00, hdr_occ} + {2'b00, inflight} + (AW+2)'(MAX_PKT_WORDS);
    admit     = hdr_hit && (need <= (AW+2)'(QUEUE_SIZE));
    write_now = 1'b0;
    wr_q      = cur_q;
    wr_addr   = cur_wptr;
    len_next  = cur_len;
    commit    = 1'b0;
    rollback  = 1'b0;
    case (state)
      IDLE: begin
        if (take && is_header) begin
          if (admit) begin
            write_now = 1'b1;
            wr_q      = hdr_q;
            wr_addr   = hdr_wptr;
            len_next  = AW'(1);
            if (is_tlast) commit = 1'b1;
            else          next_state = WRITE;
          end else if (!is_tlast) begin
            next_state = DROP;
          end
        end
      end
      WRITE: begin
        if (take) begin
          write_now = 1'b1;
          len_next  = cur_len + AW'(1);
          if (is_tlast) begin
            commit     = 1'b1;
            next_state = IDLE;
          end else if (len_next == AW'(MAX_PKT_WORDS)) begin
            rollback   = 1'b1;
            next_state = DROP;
          end
        end
      end
      DROP: begin
        if (take && is_tlast) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pointer, occupancy and output-register updates; a stalled request is held until sram_ready.
  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wptr[q] <= region_base(q);
        cptr[q] <= region_base(q);
        occ[q]  <= '0;
      end
      cur_q     <= 3'd0;
      cur_len   <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      pkt_done  <= 1'b0;
      pkt_qid   <= 3'd0;
      pkt_words <= '0;
    end else begin
      if (write_now) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= wr_addr;
        wr_data_r <= bus.din[DATA_WIDTH+9:10];
        cur_q     <= wr_q;
        cur_len   <= len_next;
      end else if (bus.sram_ready) begin
        wr_en_r <= 1'b0;
      end
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (write_now && wr_q == 3'(q)) begin
          if (rollback) wptr[q] <= cptr[q];
          else          wptr[q] <= advance(q, wr_addr);
          if (commit)   cptr[q] <= advance(q, wr_addr);
        end
        occ[q] <= occ[q]
                  + ((commit && wr_q == 3'(q)) ? len_next : '0)
                  - ((free_valid && free_qid == 3'(q)) ? free_words : '0);
      end
      pkt_done <= commit;
      if (commit) begin
        pkt_qid   <= wr_q;
        pkt_words <= len_next;
      end
    end
  end
endmodule

// File: tb/tb_fifo_to_sram_writer.sv
// Directed bench for fifo_to_sram_writer with a small queue region so wrap and space limits are reachable.
module tb_fifo_to_sram_writer;
  localparam int AW = 19, DW = 192, NQ = 5, QS = 128, MAXW = 66;

  logic          memclk = 1'b0;
  logic          memreset;
  logic          free_valid;
  logic [2:0]    free_qid;
  logic [AW-1:0] free_words;
  logic          pkt_done;
  logic [2:0]    pkt_qid;
  logic [AW-1:0] pkt_words;
  logic [NQ*AW-1:0] q_occupancy;

  int checks = 0, errors = 0, done_cnt = 0;
  int mark, dsave;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  logic [AW-1:0] wrap_exp[3];

  fifo_to_sram_writer_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_QUEUES(NQ)) bus ();

  fifo_to_sram_writer #(
    .NUM_QUEUES(NQ), .MEM_ADDR_WIDTH(AW), .QUEUE_SIZE(QS), .MAX_PKT_WORDS(MAXW), .DATA_WIDTH(DW)
  ) dut (
    .memclk(memclk), .memreset(memreset), .bus(bus),
    .free_valid(free_valid), .free_qid(free_qid), .free_words(free_words),
    .pkt_done(pkt_done), .pkt_qid(pkt_qid), .pkt_words(pkt_words), .q_occupancy(q_occupancy)
  );

  always #5 memclk = ~memclk;

  // Requests seen at the falling edge with sram_ready high are the ones the SRAM takes next edge.
  always @(negedge memclk) begin
    if (!memreset) begin
      if (bus.sram_wr_en && bus.sram_ready) begin
        log_addr.push_back(bus.sram_addr);
        log_data.push_back(bus.sram_wr_data);
      end
      if (pkt_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+9:0] mk(input logic [DW-1:0] p, input logic hdr, input logic last);
    return {p, 5'd0, (hdr ? 3'd0 : 3'd1), last, 1'b1};
  endfunction

  function automatic logic [AW-1:0] occ(input int q);
    return q_occupancy[q*AW +: AW];
  endfunction

  task automatic push(input logic [DW+9:0] e);
    int waits = 0;
    bus.din = e;
    bus.din_valid = 1'b1;
    #1;
    while (!bus.rd_en && waits < 100) begin
      @(negedge memclk);
      waits++;
    end
    if (waits == 100) check("rd_en_timeout", bus.rd_en, 1);
    @(posedge memclk);
    #1;
  endtask

  task automatic send_pkt(input logic [NQ-1:0] o, input int n, input logic [DW-1:0] base);
    bus.oq = o;
    for (int i = 0; i < n; i++) push(mk(base + DW'(i), i == 0, i == n - 1));
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge memclk);
    #1;
  endtask

  task automatic release_words(input logic [2:0] q, input logic [AW-1:0] w);
    free_valid = 1'b1;
    free_qid   = q;
    free_words = w;
    @(posedge memclk);
    #1;
    free_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    memreset = 1'b1;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.oq = '0;
    bus.sram_ready = 1'b1;
    free_valid = 1'b0;
    free_qid = 3'd0;
    free_words = '0;
    repeat (3) @(posedge memclk);
    #1;
    check("rst_wr_en", bus.sram_wr_en, 0);
    check("rst_addr", bus.sram_addr, 0);
    check("rst_data", bus.sram_wr_data, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_qid", pkt_qid, 0);
    check("rst_pkt_words", pkt_words, 0);
    check("rst_occ", q_occupancy, 0);
    check("rst_rd_en", bus.rd_en, 0);
    memreset = 1'b0;
    idle(2);

    // Single packet; oq has bits 2 and 4 set, lowest set bit selects queue 2 at base 256.
    mark = log_addr.size();
    send_pkt(5'b10100, 4, 'h100);
    check("t1_done", pkt_done, 1);
    check("t1_qid", pkt_qid, 2);
    check("t1_words", pkt_words, 4);
    check("t1_wr_en_with_done", bus.sram_wr_en, 1);
    check("t1_last_addr", bus.sram_addr, 259);
    check("t1_last_data", bus.sram_wr_data, 'h103);
    idle(3);
    check("t1_pulse_end", pkt_done, 0);
    check("t1_occ", occ(2), 4);
    check("t1_nwrites", log_addr.size() - mark, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", log_addr[mark+i], 256 + i);
      check("t1_data", log_data[mark+i], 'h100 + i);
    end

    // Fill queue 0 to QS-65, then a packet must be popped and dropped.
    send_pkt(5'b00001, 63, 'h200);
    check("t2_fill_words", pkt_words, 63);
    idle(3);
    check("t2_fill_occ", occ(0), 63);
    mark = log_addr.size();
    dsave = done_cnt;
    send_pkt(5'b00001, 4, 'h300);
    idle(3);
    check("t2_drop_writes", log_addr.size() - mark, 0);
    check("t2_drop_done", done_cnt, dsave);
    check("t2_drop_occ", occ(0), 63);

    // Walk queue 1's write pointer to top-1 (254) and wrap a 3-word packet.
    send_pkt(5'b00010, 60, 'h1000);
    idle(2);
    release_words(3'd1, 60);
    idle(1);
    check("t3_occ_released", occ(1), 0);
    send_pkt(5'b00010, 60, 'h2000);
    idle(2);
    release_words(3'd1, 60);
    send_pkt(5'b00010, 6, 'h3000);
    idle(2);
    release_words(3'd1, 6);
    mark = log_addr.size();
    send_pkt(5'b00010, 3, 'h4000);
    check("t3_words", pkt_words, 3);
    idle(3);
    wrap_exp[0] = 254;
    wrap_exp[1] = 255;
    wrap_exp[2] = 128;
    check("t3_nwrites", log_addr.size() - mark, 3);
    for (int i = 0; i < 3; i++) begin
      check("t3_addr", log_addr[mark+i], wrap_exp[i]);
      check("t3_data", log_data[mark+i], 'h4000 + i);
    end
    check("t3_occ", occ(1), 3);

    // Backpressure on queue 2 (write pointer now 260) while the third entry is registered.
    mark = log_addr.size();
    bus.oq = 5'b00100;
    push(mk('h400, 1'b1, 1'b0));
    push(mk('h401, 1'b0, 1'b0));
    push(mk('h402, 1'b0, 1'b0));
    bus.sram_ready = 1'b0;
    bus.din = mk('h403, 1'b0, 1'b0);
    #1;
    check("t4_rd_en_stall", bus.rd_en, 0);
    check("t4_wr_en_held", bus.sram_wr_en, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge memclk);
      #2;
      check("t4_rd_en_stall", bus.rd_en, 0);
      check("t4_addr_held", bus.sram_addr, 262);
      check("t4_data_held", bus.sram_wr_data, 'h402);
    end
    bus.sram_ready = 1'b1;
    push(mk('h403, 1'b0, 1'b0));
    push(mk('h404, 1'b0, 1'b0));
    push(mk('h405, 1'b0, 1'b1));
    bus.din_valid = 1'b0;
    check("t4_words", pkt_words, 6);
    idle(3);
    check("t4_nwrites", log_addr.size() - mark, 6);
    for (int i = 0; i < 6; i++) begin
      check("t4_addr", log_addr[mark+i], 260 + i);
      check("t4_data", log_data[mark+i], 'h400 + i);
    end
    check("t4_occ", occ(2), 10);

    // Commit of 4 words and release of 10 words on queue 3 in the same cycle, from 20.
    send_pkt(5'b01000, 20, 'h5000);
    idle(2);
    check("t5_occ_start", occ(3), 20);
    bus.oq = 5'b01000;
    push(mk('h5100, 1'b1, 1'b0));
    push(mk('h5101, 1'b0, 1'b0));
    push(mk('h5102, 1'b0, 1'b0));
    free_valid = 1'b1;
    free_qid   = 3'd3;
    free_words = 10;
    push(mk('h5103, 1'b0, 1'b1));
    free_valid = 1'b0;
    bus.din_valid = 1'b0;
    check("t5_qid", pkt_qid, 3);
    check("t5_words", pkt_words, 4);
    idle(1);
    check("t5_occ_net", occ(3), 14);

    // Overlength packet on queue 4: 66 writes, rollback, rest dropped, no commit.
    mark = log_addr.size();
    dsave = done_cnt;
    send_pkt(5'b10000, 70, 'h6000);
    idle(3);
    check("t6_nwrites", log_addr.size() - mark, 66);
    check("t6_last_addr", log_addr[mark+65], 577);
    check("t6_no_done", done_cnt, dsave);
    check("t6_occ", occ(4), 0);
    mark = log_addr.size();
    send_pkt(5'b10000, 2, 'h7000);
    check("t6_next_words", pkt_words, 2);
    idle(3);
    check("t6_rollback_addr0", log_addr[mark], 512);
    check("t6_rollback_addr1", log_addr[mark+1], 513);
    check("t6_next_occ", occ(4), 2);

    // Reset in the middle of a packet returns pointers to their region bases.
    bus.oq = 5'b00100;
    push(mk('h8000, 1'b1, 1'b0));
    push(mk('h8001, 1'b0, 1'b0));
    memreset = 1'b1;
    #2;
    check("t7_rst_wr_en", bus.sram_wr_en, 0);
    check("t7_rst_occ", q_occupancy, 0);
    bus.din_valid = 1'b0;
    idle(1);
    memreset = 1'b0;
    idle(1);
    mark = log_addr.size();
    send_pkt(5'b00100, 2, 'h9000);
    idle(3);
    check("t7_base_addr", log_addr[mark], 256);
    check("t7_occ", occ(2), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
